id_ex_hazard_reg: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32 core. It captures the decode-stage control bundle (from the main decoder) together with operands, immediate, function bits and register addresses, and presents them to EX. It produces the no-op request that the decoder consumes, plus the stall request for the PC and IF/ID register. It inserts bubbles on load-use hazards and branch flushes, and keeps saturating stall/flush event counters for performance debug.

---
 rtl/core_pkg.sv | 35 +++
 rtl/hazard_detect.sv | 36 +++
 rtl/id_ex_hazard_reg.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline types and constants for the RV32 core
//
// Purpose : Types shared by the decode/execute pipeline blocks.
// Contents: ALUOp encodings, the decoder control bundle ctrl_t and the
//           all-zero bubble constant.

package core_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int FUNCT_W    = 10;

   // ALU operation classes produced by the main decoder
   typedef enum logic [1:0] {
      ALUOP_LDST  = 2'b00,
      ALUOP_BEQ   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ITYPE = 2'b11
   } aluop_e;

   // Decoder control bundle carried from ID into EX
   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
   } ctrl_t;

   // A bubble carries no side effects: no write-back, no memory access,
   // no branch, and ALUSrc cleared as well.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detector
//
// Purpose : Flags a load in EX whose destination is read by the ID instruction.
// Ports   :
//   valid_ex_i    EX holds a real instruction
//   mem_read_ex_i EX instruction is a load
//   rd_ex_i       EX destination register
//   valid_id_i    ID holds a real instruction
//   rs1_id_i      ID source register 1
//   rs2_id_i      ID source register 2
//   hazard_o      load-use hazard present

module hazard_detect
   import core_pkg::*;
(
   input  logic                  valid_ex_i,
   input  logic                  mem_read_ex_i,
   input  logic [REG_ADDR_W-1:0] rd_ex_i,
   input  logic                  valid_id_i,
   input  logic [REG_ADDR_W-1:0] rs1_id_i,
   input  logic [REG_ADDR_W-1:0] rs2_id_i,
   output logic                  hazard_o
);

   logic rd_nonzero;
   logic rs_match;

   always_comb begin
      rd_nonzero = (rd_ex_i != '0);
      // rs2 is compared for every format; I-type instructions may stall
      // needlessly on their immediate bits, which is accepted.
      rs_match   = (rd_ex_i == rs1_id_i) | (rd_ex_i == rs2_id_i);
      hazard_o   = valid_id_i & valid_ex_i & mem_read_ex_i & rd_nonzero & rs_match;
   end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// rtl/id_ex_hazard_reg.sv - ID/EX pipeline register with load-use hazard handling
//
// Purpose : Captures the decode-stage control bundle, operands, immediate,
//           function bits and register indices and presents them to EX.
//           Inserts bubbles on load-use hazards and branch flushes and keeps
//           saturating stall/flush event counters.
// Ports   :
//   clk_i, rst_i               clock, synchronous active-high reset
//   valid_i, flush_i           ID instruction valid, branch flush
//   ALUOp_i .. Branch_i        decoder control bits
//   RS1data_i, RS2data_i       register operands
//   Imm_i, funct_i             immediate, {funct7, funct3}
//   RS1addr_i .. RDaddr_i      register indices
//   ALUOp_o .. RDaddr_o        registered EX-stage copies
//   valid_o                    EX holds a real instruction
//   NoOp_o, Stall_o            combinational hazard outputs
//   stall_cnt_o, flush_cnt_o   saturating event counters

module id_ex_hazard_reg
   import core_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic                  flush_i,
   input  logic [1:0]            ALUOp_i,
   input  logic                  ALUSrc_i,
   input  logic                  RegWrite_i,
   input  logic                  MemtoReg_i,
   input  logic                  MemRead_i,
   input  logic                  MemWrite_i,
   input  logic                  Branch_i,
   input  logic [XLEN-1:0]       RS1data_i,
   input  logic [XLEN-1:0]       RS2data_i,
   input  logic [XLEN-1:0]       Imm_i,
   input  logic [FUNCT_W-1:0]    funct_i,
   input  logic [REG_ADDR_W-1:0] RS1addr_i,
   input  logic [REG_ADDR_W-1:0] RS2addr_i,
   input  logic [REG_ADDR_W-1:0] RDaddr_i,
   output logic [1:0]            ALUOp_o,
   output logic                  ALUSrc_o,
   output logic                  RegWrite_o,
   output logic                  MemtoReg_o,
   output logic                  MemRead_o,
   output logic                  MemWrite_o,
   output logic                  Branch_o,
   output logic [XLEN-1:0]       RS1data_o,
   output logic [XLEN-1:0]       RS2data_o,
   output logic [XLEN-1:0]       Imm_o,
   output logic [FUNCT_W-1:0]    funct_o,
   output logic [REG_ADDR_W-1:0] RS1addr_o,
   output logic [REG_ADDR_W-1:0] RS2addr_o,
   output logic [REG_ADDR_W-1:0] RDaddr_o,
   output logic                  valid_o,
   output logic                  NoOp_o,
   output logic                  Stall_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   ctrl_t                 ctrl_q,      ctrl_d;
   logic                  valid_q,     valid_d;
   logic [XLEN-1:0]       rs1_data_q,  rs1_data_d;
   logic [XLEN-1:0]       rs2_data_q,  rs2_data_d;
   logic [XLEN-1:0]       imm_q,       imm_d;
   logic [FUNCT_W-1:0]    funct_q,     funct_d;
   logic [REG_ADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
   logic [REG_ADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
   logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

   ctrl_t ctrl_in;
   logic  hazard;
   logic  stall;
   logic  bubble;

   always_comb begin
      ctrl_in            = CTRL_BUBBLE;
      ctrl_in.alu_op     = ALUOp_i;
      ctrl_in.alu_src    = ALUSrc_i;
      ctrl_in.reg_write  = RegWrite_i;
      ctrl_in.mem_to_reg = MemtoReg_i;
      ctrl_in.mem_read   = MemRead_i;
      ctrl_in.mem_write  = MemWrite_i;
      ctrl_in.branch     = Branch_i;
   end

   // ------------------------------------------------------------------
   // Hazard detection: looks only at registered EX state plus ID indices
   // and valid, so the decoder's no-op forcing cannot loop back into it.
   // ------------------------------------------------------------------
   hazard_detect u_hazard_detect (
      .valid_ex_i    (valid_q),
      .mem_read_ex_i (ctrl_q.mem_read),
      .rd_ex_i       (rd_addr_q),
      .valid_id_i    (valid_i),
      .rs1_id_i      (RS1addr_i),
      .rs2_id_i      (RS2addr_i),
      .hazard_o      (hazard)
   );

   // A flush discards the ID instruction anyway, so it overrides the stall.
   always_comb begin
      stall  = hazard & ~flush_i & ~rst_i;
      bubble = hazard | flush_i;
   end

   assign Stall_o = stall;
   assign NoOp_o  = stall;

   // ------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------
   always_comb begin
      ctrl_d      = ctrl_in;
      valid_d     = valid_i;
      rs1_data_d  = RS1data_i;
      rs2_data_d  = RS2data_i;
      imm_d       = Imm_i;
      funct_d     = funct_i;
      rs1_addr_d  = RS1addr_i;
      rs2_addr_d  = RS2addr_i;
      rd_addr_d   = RDaddr_i;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      // Bubble zeroes control directly rather than trusting the decoder's
      // no-op path; data fields still track the inputs so they stay defined.
      if (bubble) begin
         ctrl_d    = CTRL_BUBBLE;
         valid_d   = 1'b0;
         rd_addr_d = '0;
      end

      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_i && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q      <= CTRL_BUBBLE;
         valid_q     <= 1'b0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         funct_q     <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_addr_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         funct_q     <= funct_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_addr_q   <= rd_addr_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ALUOp_o     = ctrl_q.alu_op;
   assign ALUSrc_o    = ctrl_q.alu_src;
   assign RegWrite_o  = ctrl_q.reg_write;
   assign MemtoReg_o  = ctrl_q.mem_to_reg;
   assign MemRead_o   = ctrl_q.mem_read;
   assign MemWrite_o  = ctrl_q.mem_write;
   assign Branch_o    = ctrl_q.branch;
   assign RS1data_o   = rs1_data_q;
   assign RS2data_o   = rs2_data_q;
   assign Imm_o       = imm_q;
   assign funct_o     = funct_q;
   assign RS1addr_o   = rs1_addr_q;
   assign RS2addr_o   = rs2_addr_q;
   assign RDaddr_o    = rd_addr_q;
   assign valid_o     = valid_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb/tb_id_ex_hazard_reg.sv - self-checking bench for id_ex_hazard_reg

module tb_id_ex_hazard_reg;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid_in, flush;
   logic [1:0]  aluop_in;
   logic        alusrc_in, regwrite_in, memtoreg_in, memread_in, memwrite_in, branch_in;
   logic [31:0] rs1d_in, rs2d_in, imm_in;
   logic [9:0]  funct_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;

   logic [1:0]  aluop_out;
   logic        alusrc_out, regwrite_out, memtoreg_out, memread_out, memwrite_out, branch_out;
   logic [31:0] rs1d_out, rs2d_out, imm_out;
   logic [9:0]  funct_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic        valid_out, noop_out, stall_out;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   id_ex_hazard_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .flush_i(flush),
      .ALUOp_i(aluop_in), .ALUSrc_i(alusrc_in), .RegWrite_i(regwrite_in),
      .MemtoReg_i(memtoreg_in), .MemRead_i(memread_in), .MemWrite_i(memwrite_in),
      .Branch_i(branch_in), .RS1data_i(rs1d_in), .RS2data_i(rs2d_in), .Imm_i(imm_in),
      .funct_i(funct_in), .RS1addr_i(rs1_in), .RS2addr_i(rs2_in), .RDaddr_i(rd_in),
      .ALUOp_o(aluop_out), .ALUSrc_o(alusrc_out), .RegWrite_o(regwrite_out),
      .MemtoReg_o(memtoreg_out), .MemRead_o(memread_out), .MemWrite_o(memwrite_out),
      .Branch_o(branch_out), .RS1data_o(rs1d_out), .RS2data_o(rs2d_out), .Imm_o(imm_out),
      .funct_o(funct_out), .RS1addr_o(rs1_out), .RS2addr_o(rs2_out), .RDaddr_o(rd_out),
      .valid_o(valid_out), .NoOp_o(noop_out), .Stall_o(stall_out),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   typedef struct {
      bit        rst, valid, flush;
      bit [1:0]  aluop;
      bit        alusrc, regwrite, memtoreg, memread, memwrite, branch;
      bit [31:0] rs1d, rs2d, imm;
      bit [9:0]  funct;
      bit [4:0]  rs1, rs2, rd;
   } instr_t;

   // Reference model: contents of the EX stage plus event counts
   instr_t ex;
   bit     ex_data_known;
   int     m_stall_cnt, m_flush_cnt;
   logic   obs_stall;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t rnd();
      instr_t t;
      t.rst      = 1'b0;
      t.valid    = 1'b1;
      t.flush    = 1'b0;
      t.aluop    = 2'($urandom_range(3, 0));
      t.alusrc   = 1'($urandom);
      t.regwrite = 1'($urandom);
      t.memtoreg = 1'($urandom);
      t.memread  = 1'($urandom);
      t.memwrite = 1'($urandom);
      t.branch   = 1'($urandom);
      t.rs1d     = $urandom;
      t.rs2d     = $urandom;
      t.imm      = $urandom;
      t.funct    = 10'($urandom);
      t.rs1      = 5'($urandom_range(4, 0));
      t.rs2      = 5'($urandom_range(4, 0));
      t.rd       = 5'($urandom_range(4, 0));
      return t;
   endfunction

   function automatic instr_t lw(input bit [4:0] rd, input bit [4:0] base, input bit [4:0] rs2f);
      instr_t t = rnd();
      t.aluop = 2'b00; t.alusrc = 1; t.regwrite = 1; t.memtoreg = 1;
      t.memread = 1; t.memwrite = 0; t.branch = 0;
      t.rd = rd; t.rs1 = base; t.rs2 = rs2f;
      return t;
   endfunction

   function automatic instr_t rtype(input bit [4:0] rd, input bit [4:0] a, input bit [4:0] b);
      instr_t t = rnd();
      t.aluop = 2'b10; t.alusrc = 0; t.regwrite = 1; t.memtoreg = 0;
      t.memread = 0; t.memwrite = 0; t.branch = 0;
      t.rd = rd; t.rs1 = a; t.rs2 = b;
      return t;
   endfunction

   // Called one time unit after a rising edge; leaves time at the same phase.
   task automatic cycle(input instr_t t);
      bit h, st;
      rst = t.rst; valid_in = t.valid; flush = t.flush;
      aluop_in = t.aluop; alusrc_in = t.alusrc; regwrite_in = t.regwrite;
      memtoreg_in = t.memtoreg; memread_in = t.memread; memwrite_in = t.memwrite;
      branch_in = t.branch; rs1d_in = t.rs1d; rs2d_in = t.rs2d; imm_in = t.imm;
      funct_in = t.funct; rs1_in = t.rs1; rs2_in = t.rs2; rd_in = t.rd;
      #2;
      // Load-use: EX is a real load writing a nonzero register the ID instruction reads
      h  = t.valid && ex.valid && ex.memread && (ex.rd != 0) &&
           ((ex.rd == t.rs1) || (ex.rd == t.rs2));
      st = h && !t.flush && !t.rst;
      obs_stall = stall_out;
      check("stall", 64'(stall_out), 64'(st));
      check("noop", 64'(noop_out), 64'(st));
      @(posedge clk);
      if (t.rst) begin
         ex = '{default: 0};
         ex_data_known = 1;
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (st) m_stall_cnt = (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : CNT_MAX;
         if (t.flush) m_flush_cnt = (m_flush_cnt < CNT_MAX) ? m_flush_cnt + 1 : CNT_MAX;
         ex = t;
         ex_data_known = 1;
         if (t.flush || h) begin
            ex.valid = 0; ex.aluop = 0; ex.alusrc = 0; ex.regwrite = 0;
            ex.memtoreg = 0; ex.memread = 0; ex.memwrite = 0; ex.branch = 0;
            ex.rd = 0;
            ex_data_known = 0;
         end
      end
      #1;
      check("valid_o", 64'(valid_out), 64'(ex.valid));
      check("ctrl_o",
            64'({aluop_out, alusrc_out, regwrite_out, memtoreg_out, memread_out, memwrite_out, branch_out}),
            64'({ex.aluop, ex.alusrc, ex.regwrite, ex.memtoreg, ex.memread, ex.memwrite, ex.branch}));
      check("rd_o", 64'(rd_out), 64'(ex.rd));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
      check("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
      if (ex_data_known) begin
         check("data_o", {rs1d_out, rs2d_out}, {ex.rs1d, ex.rs2d});
         check("imm_o", 64'(imm_out), 64'(ex.imm));
         check("fields_o", 64'({funct_out, rs1_out, rs2_out}), 64'({ex.funct, ex.rs1, ex.rs2}));
      end
   endtask

   task automatic do_reset();
      instr_t t;
      repeat (2) begin
         t = rnd();
         t.rst = 1;
         t.valid = 1'($urandom);
         t.flush = 1'($urandom);
         cycle(t);
      end
   endtask

   initial begin
      instr_t t;
      ex = '{default: 0};
      ex_data_known = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      @(posedge clk);
      #1;

      // Reset
      do_reset();
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

      // Load-use: lw x5 ; add x6,x5,x1 (re-presented after the stall)
      cycle(lw(5'd5, 5'd2, 5'd0));
      cycle(rtype(5'd6, 5'd5, 5'd1));
      check("lu_stall", 64'(obs_stall), 64'd1);
      check("lu_bubble_valid", 64'(valid_out), 64'd0);
      check("lu_bubble_regwrite", 64'(regwrite_out), 64'd0);
      cycle(rtype(5'd6, 5'd5, 5'd1));
      check("lu_restall", 64'(obs_stall), 64'd0);
      check("lu_add_valid", 64'(valid_out), 64'd1);
      check("lu_add_rd", 64'(rd_out), 64'd6);
      check("lu_cnt", 64'(stall_cnt), 64'd1);

      // x0 destination, unrelated readers, back-to-back loads
      do_reset();
      cycle(lw(5'd0, 5'd2, 5'd0));
      cycle(rtype(5'd6, 5'd0, 5'd0));
      check("x0_nostall", 64'(obs_stall), 64'd0);
      cycle(lw(5'd5, 5'd2, 5'd9));
      cycle(rtype(5'd6, 5'd7, 5'd8));
      check("unrel_nostall", 64'(obs_stall), 64'd0);
      cycle(lw(5'd5, 5'd2, 5'd9));
      cycle(lw(5'd5, 5'd3, 5'd9));
      check("lwlw_nostall", 64'(obs_stall), 64'd0);
      check("nostall_cnt", 64'(stall_cnt), 64'd0);

      // Flush together with a hazard
      do_reset();
      cycle(lw(5'd5, 5'd2, 5'd0));
      t = rtype(5'd6, 5'd5, 5'd1);
      t.flush = 1;
      cycle(t);
      check("fh_stall", 64'(obs_stall), 64'd0);
      check("fh_valid", 64'(valid_out), 64'd0);
      check("fh_flush_cnt", 64'(flush_cnt), 64'd1);
      check("fh_stall_cnt", 64'(stall_cnt), 64'd0);

      // Reset asserted while a stall is pending
      do_reset();
      cycle(lw(5'd5, 5'd2, 5'd0));
      t = rtype(5'd6, 5'd5, 5'd1);
      t.rst = 1;
      cycle(t);
      check("rs_stall", 64'(obs_stall), 64'd0);
      check("rs_cnt", 64'(stall_cnt), 64'd0);
      check("rs_memread", 64'(memread_out), 64'd0);

      // Saturation: 20 load-use stalls on a 4-bit counter
      do_reset();
      repeat (20) begin
         cycle(lw(5'd5, 5'd2, 5'd0));
         cycle(rtype(5'd6, 5'd1, 5'd5));
         cycle(rtype(5'd6, 5'd1, 5'd5));
      end
      check("sat_stall_cnt", 64'(stall_cnt), 64'd15);

      // Pass-through: addi x3,x2,7
      t = rnd();
      t.aluop = 2'b11; t.alusrc = 1; t.regwrite = 1; t.memtoreg = 0;
      t.memread = 0; t.memwrite = 0; t.branch = 0;
      t.imm = 32'd7; t.rd = 5'd3; t.rs1 = 5'd2; t.rs2 = 5'd7;
      cycle(t);
      check("pt_aluop", 64'(aluop_out), 64'd3);
      check("pt_alusrc", 64'(alusrc_out), 64'd1);
      check("pt_imm", 64'(imm_out), 64'd7);
      check("pt_rd", 64'(rd_out), 64'd3);
      check("pt_valid", 64'(valid_out), 64'd1);

      // Randomized traffic over a small register set to provoke hazards
      for (int i = 0; i < 600; i++) begin
         t = rnd();
         t.valid = ($urandom_range(99, 0) < 85);
         t.flush = ($urandom_range(99, 0) < 10);
         t.rst   = ($urandom_range(99, 0) < 2);
         if ($urandom_range(1, 0) == 1) t.memread = 1;
         cycle(t);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
